// File: rtl/riscv_lsu_pkg.sv
// ----------------------------------------------------------------------------
// riscv_lsu_pkg
// Shared types for the load/store unit back end: FSM state encoding, access
// size encodings and the word-crossing predicate.
// No ports (package). Imported by lsu_lane_align and dmem_lsu_master.
// ----------------------------------------------------------------------------
package riscv_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP,
        WR_A,
        WR_B,
        RSP
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;   // 2'd3 decodes as word as well

    // An access crosses into the next word when its last byte lies beyond
    // byte lane 3 of the first word.
    function automatic logic lsu_crossing(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && (off == 2'd3)) || (size[1] && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane steering for the LSU. Works on the 64-bit little-endian
// pair {hi, lo} so that word-crossing accesses use the same datapath.
//   i_size   access size (SZ_BYTE / SZ_HALF / word)
//   i_uns    zero-extend the load result
//   i_off    byte offset inside the first word
//   i_lo     first (lower-addressed) memory word
//   i_hi     second memory word (zero when unused)
//   i_wdata  right-aligned store data
//   o_rdata  extracted, extended load data
//   o_merged {hi, lo} with the store bytes merged in
// ----------------------------------------------------------------------------
module lsu_lane_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [63:0] o_merged
);

    logic [63:0] w_cat;
    logic [5:0]  w_sh;
    logic [31:0] w_ext;
    logic [63:0] w_szmask;
    logic [63:0] w_mask;
    logic [63:0] w_wsh;

    assign w_cat = {i_hi, i_lo};
    assign w_sh  = {1'b0, i_off, 3'b000};
    assign w_ext = 32'(w_cat >> w_sh);

    always_comb begin
        w_szmask = 64'h0000_0000_FFFF_FFFF;
        o_rdata  = w_ext;
        case (i_size)
            SZ_BYTE: begin
                w_szmask = 64'h0000_0000_0000_00FF;
                o_rdata  = {{24{~i_uns & w_ext[7]}}, w_ext[7:0]};
            end
            SZ_HALF: begin
                w_szmask = 64'h0000_0000_0000_FFFF;
                o_rdata  = {{16{~i_uns & w_ext[15]}}, w_ext[15:0]};
            end
            default: ;
        endcase
    end

    assign w_mask   = w_szmask << w_sh;
    assign w_wsh    = {32'h0, i_wdata} << w_sh;
    assign o_merged = (w_cat & ~w_mask) | (w_wsh & w_mask);

endmodule

// File: rtl/dmem_lsu_master.sv
// ----------------------------------------------------------------------------
// dmem_lsu_master
// LSU back end: takes byte/half/word loads and stores from the MEM stage and
// drives a word-wide, word-indexed DMEM with one-cycle registered read latency.
// Sub-word stores are read-modify-write (no byte enables on the memory).
//
// Build option: LSU_MISALIGNED_EN
//   defined   - word-crossing accesses are split into two word transactions
//   undefined - crossing requests complete at once with rsp_misaligned_o = 1
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   req_valid_i/ready_o     request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             last load result, held between load responses
//   rsp_misaligned_o        crossing access rejected (qualifies rsp_valid_o)
//   DMEM_*                  word-indexed memory port
// ----------------------------------------------------------------------------
module dmem_lsu_master
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_misaligned_o,
    output logic [ADDR_WIDTH-1:0] DMEM_addr_o,
    output logic                  DMEM_read_o,
    output logic                  DMEM_write_o,
    output logic [31:0]           DMEM_data_o,
    input  logic [31:0]           DMEM_data_i
);

    lsu_state_e            r_state, w_next;
    logic                  r_we, r_uns, r_cross;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_lo;      // word A: store data, read data, then merged data
    logic [31:0]           r_rdata;
`ifdef LSU_MISALIGNED_EN
    logic [31:0]           r_hi;      // merged word B
`endif

    logic                  w_hs, w_req_cross, w_req_wsw;
    logic [ADDR_WIDTH-3:0] w_idx_a, w_idx_b;
    logic [31:0]           w_cap_lo, w_cap_hi, w_ld_data;
    logic [63:0]           w_merged;

    assign req_ready_o = reset_n & (r_state == IDLE);
    assign w_hs        = req_valid_i & req_ready_o;
    assign w_req_cross = lsu_crossing(req_size_i, req_addr_i[1:0]);
    // Aligned full-word store needs no read: the store data is the word.
    assign w_req_wsw   = req_we_i & req_size_i[1] & (req_addr_i[1:0] == 2'b00);

    assign w_idx_a = r_addr[ADDR_WIDTH-1:2];
    assign w_idx_b = w_idx_a + (ADDR_WIDTH-2)'(1);   // wraps at the top of memory

    // In CAP the memory is presenting the last word read. For a split access
    // word A was parked in r_lo during RD_B.
`ifdef LSU_MISALIGNED_EN
    assign w_cap_lo = r_cross ? r_lo : DMEM_data_i;
    assign w_cap_hi = r_cross ? DMEM_data_i : 32'h0;
`else
    assign w_cap_lo = DMEM_data_i;
    assign w_cap_hi = 32'h0;
    logic w_unused_hi;
    assign w_unused_hi = ^w_merged[63:32];
`endif

    lsu_lane_align u_align (
        .i_size   (r_size),
        .i_uns    (r_uns),
        .i_off    (r_addr[1:0]),
        .i_lo     (w_cap_lo),
        .i_hi     (w_cap_hi),
        .i_wdata  (r_wdata),
        .o_rdata  (w_ld_data),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_cross <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_lo    <= 32'h0;
            r_rdata <= 32'h0;
`ifdef LSU_MISALIGNED_EN
            r_hi    <= 32'h0;
`endif
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_we    <= req_we_i;
                r_uns   <= req_unsigned_i;
                r_cross <= w_req_cross;
                r_size  <= req_size_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_lo    <= req_wdata_i;
            end
`ifdef LSU_MISALIGNED_EN
            if (r_state == RD_B) r_lo <= DMEM_data_i;
`endif
            if (r_state == CAP) begin
                if (r_we) begin
                    r_lo <= w_merged[31:0];
`ifdef LSU_MISALIGNED_EN
                    r_hi <= w_merged[63:32];
`endif
                end else begin
                    r_rdata <= w_ld_data;
                end
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        DMEM_read_o  = 1'b0;
        DMEM_write_o = 1'b0;
        DMEM_addr_o  = '0;
        DMEM_data_o  = 32'h0;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_next = w_req_wsw ? WR_A : RD_A;
`ifndef LSU_MISALIGNED_EN
                    if (w_req_cross) w_next = RSP;
`endif
                end
            end
            RD_A: begin
                DMEM_read_o = 1'b1;
                DMEM_addr_o = {2'b00, w_idx_a};
                w_next      = CAP;
`ifdef LSU_MISALIGNED_EN
                if (r_cross) w_next = RD_B;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            RD_B: begin
                DMEM_read_o = 1'b1;
                DMEM_addr_o = {2'b00, w_idx_b};
                w_next      = CAP;
            end
`endif
            CAP: w_next = r_we ? WR_A : RSP;
            WR_A: begin
                DMEM_write_o = 1'b1;
                DMEM_addr_o  = {2'b00, w_idx_a};
                DMEM_data_o  = r_lo;
                w_next       = RSP;
`ifdef LSU_MISALIGNED_EN
                if (r_cross) w_next = WR_B;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            WR_B: begin
                DMEM_write_o = 1'b1;
                DMEM_addr_o  = {2'b00, w_idx_b};
                DMEM_data_o  = r_hi;
                w_next       = RSP;
            end
`endif
            RSP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign rsp_valid_o = (r_state == RSP);
    assign rsp_rdata_o = r_rdata;
`ifdef LSU_MISALIGNED_EN
    assign rsp_misaligned_o = 1'b0;
`else
    assign rsp_misaligned_o = (r_state == RSP) & r_cross;
`endif

endmodule

// File: tb/tb_dmem_lsu_master.sv
// ----------------------------------------------------------------------------
// tb_dmem_lsu_master
// Directed bench for dmem_lsu_master with a behavioural DMEM (one-cycle
// registered read) and a scoreboard of expected responses. Follows the
// LSU_MISALIGNED_EN setting of the build.
// ----------------------------------------------------------------------------
module tb_dmem_lsu_master;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_misaligned_o;
    logic [31:0] DMEM_addr_o;
    logic        DMEM_read_o;
    logic        DMEM_write_o;
    logic [31:0] DMEM_data_o;
    logic [31:0] rd_q = 32'h0;

    always #5 clk = ~clk;

    dmem_lsu_master #(.ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_size_i       (req_size_i),
        .req_unsigned_i   (req_unsigned_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_misaligned_o (rsp_misaligned_o),
        .DMEM_addr_o      (DMEM_addr_o),
        .DMEM_read_o      (DMEM_read_o),
        .DMEM_write_o     (DMEM_write_o),
        .DMEM_data_o      (DMEM_data_o),
        .DMEM_data_i      (rd_q)
    );

    // Behavioural DMEM
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (DMEM_write_o) mem[DMEM_addr_o[7:0]] <= DMEM_data_o;
        if (DMEM_read_o)  rd_q <= mem[DMEM_addr_o[7:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        misal;
        int          lat;
        int          nrd;
        int          nwr;
        int          wrlat;
        logic [31:0] rdidx;
        int          hs;
    } exp_t;

    exp_t        sb[$];
    int          rd_cnt = 0, wr_cnt = 0, wr_rel = 0, last_rsp = 0;
    logic [31:0] rd_idx = 32'h0;
    logic [31:0] last_rd = 32'h0;

    // Response monitor / strobe tracker
    always @(negedge clk) begin
        exp_t e;
        chk("dmem_quiet",
            {63'h0, (DMEM_read_o && DMEM_write_o) ||
                    (DMEM_read_o && DMEM_data_o != 32'h0) ||
                    (!DMEM_read_o && !DMEM_write_o &&
                     (DMEM_addr_o != 32'h0 || DMEM_data_o != 32'h0))},
            64'h0);
        if (DMEM_read_o) begin
            if (rd_cnt == 0) rd_idx = DMEM_addr_o;
            rd_cnt++;
        end
        if (DMEM_write_o) begin
            if (wr_cnt == 0 && sb.size() > 0) wr_rel = cyc - sb[0].hs;
            wr_cnt++;
        end
        if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                chk("rsp_spurious", 64'h1, 64'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_latency", 64'(cyc - e.hs), 64'(e.lat));
                chk("rsp_rdata", {32'h0, rsp_rdata_o}, {32'h0, e.rdata});
                chk("rsp_misaligned", {63'h0, rsp_misaligned_o}, {63'h0, e.misal});
                chk("n_reads", 64'(rd_cnt), 64'(e.nrd));
                chk("n_writes", 64'(wr_cnt), 64'(e.nwr));
                chk("write_cycle", 64'(wr_rel), 64'(e.wrlat));
                chk("read_index", {32'h0, rd_idx}, {32'h0, e.rdidx});
                chk("ready_in_rsp", {63'h0, req_ready_o}, 64'h0);
                last_rsp = cyc;
            end
        end
    end

    // Drive a request (called at a negedge) and push its expected response.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erd, input int lat, input int nrd,
                         input int nwr, input int wrlat, input logic misal,
                         input logic b2b);
        exp_t e;
        int   n;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hs_timeout", {63'h0, n < 40}, 64'h1);
        if (b2b) chk("b2b_gap", 64'(cyc - last_rsp), 64'h1);
        if (!we && !misal) last_rd = erd;
        e.rdata = last_rd;
        e.misal = misal;
        e.lat   = lat;
        e.nrd   = nrd;
        e.nwr   = nwr;
        e.wrlat = wrlat;
        e.rdidx = (nrd != 0) ? (addr >> 2) : 32'h0;
        e.hs    = cyc;
        rd_cnt = 0; wr_cnt = 0; wr_rel = 0; rd_idx = 32'h0;
        sb.push_back(e);
        @(negedge clk);
        chk("ready_busy", {63'h0, req_ready_o}, 64'h0);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'h0);
        @(negedge clk);
    endtask

    task automatic preload();
        mem[4] = 32'h8877_6655;
        mem[5] = 32'hCCBB_AA99;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {63'h0, req_ready_o}, 64'h0);
        chk({tag, "_outs"},
            {26'h0, rsp_valid_o, rsp_misaligned_o, DMEM_read_o, DMEM_write_o,
             |DMEM_addr_o, |DMEM_data_o, rsp_rdata_o}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        preload();

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        #1 chk("ready_after_reset", {63'h0, req_ready_o}, 64'h1);
        @(negedge clk);

        // Aligned / in-word loads
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8877_6655, 3, 1, 0, 0, 1'b0, 1'b0); drain();
        issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 3, 1, 0, 0, 1'b0, 1'b0); drain();
        issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h0000_0088, 3, 1, 0, 0, 1'b0, 1'b0); drain();
        issue(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'hFFFF_8877, 3, 1, 0, 0, 1'b0, 1'b0); drain();
        issue(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'h0000_6655, 3, 1, 0, 0, 1'b0, 1'b0); drain();
        issue(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'h0000_0055, 3, 1, 0, 0, 1'b0, 1'b0); drain();

        // Sub-word store (read-modify-write) and aligned word store
        issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_00A5, 32'h0, 4, 1, 1, 3, 1'b0, 1'b0); drain();
        chk("mem4_after_sb", {32'h0, mem[4]}, 64'h8877_A555);
        chk("mem5_after_sb", {32'h0, mem[5]}, 64'hCCBB_AA99);
        issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hDEAD_BEEF, 32'h0, 2, 0, 1, 1, 1'b0, 1'b0); drain();
        chk("mem5_after_sw", {32'h0, mem[5]}, 64'hDEAD_BEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8877_A555, 3, 1, 0, 0, 1'b0, 1'b0); drain();

        // Word-crossing accesses
        preload();
`ifdef LSU_MISALIGNED_EN
        issue(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'hAA99_8877, 4, 2, 0, 0, 1'b0, 1'b0); drain();
        issue(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000_1234, 32'h0, 6, 2, 2, 4, 1'b0, 1'b0); drain();
        chk("mem4_after_sh", {32'h0, mem[4]}, 64'h3477_6655);
        chk("mem5_after_sh", {32'h0, mem[5]}, 64'hCCBB_AA12);
        issue(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'h0000_1234, 4, 2, 0, 0, 1'b0, 1'b0); drain();
`else
        issue(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'h0, 1, 0, 0, 0, 1'b1, 1'b0); drain();
        issue(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000_1234, 32'h0, 1, 0, 0, 0, 1'b1, 1'b0); drain();
        chk("mem4_after_sh", {32'h0, mem[4]}, 64'h8877_6655);
        chk("mem5_after_sh", {32'h0, mem[5]}, 64'hCCBB_AA99);
        issue(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'h0, 1, 0, 0, 0, 1'b1, 1'b0); drain();
`endif

        // Back-to-back with valid held high
        preload();
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8877_6655, 3, 1, 0, 0, 1'b0, 1'b0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 3, 1, 0, 0, 1'b0, 1'b1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h18, 32'h1122_3344, 32'h0, 2, 0, 1, 1, 1'b0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0, 32'h1122_3344, 3, 1, 0, 0, 1'b0, 1'b1);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_007E, 32'h0, 4, 1, 1, 3, 1'b0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h887E_6655, 3, 1, 0, 0, 1'b0, 1'b1);
        drain();
        preload();

        // Reset in the middle of a read sequence
`ifdef LSU_MISALIGNED_EN
        issue(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'hAA99_8877, 4, 2, 0, 0, 1'b0, 1'b0);
        @(negedge clk);   // now in RD_B
`else
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8877_6655, 3, 1, 0, 0, 1'b0, 1'b0);
`endif
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midop_reset");
        sb.delete();
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("ready_after_midop", {63'h0, req_ready_o}, 64'h1);
        @(negedge clk);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8877_6655, 3, 1, 0, 0, 1'b0, 1'b0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
